// File: rtl/vend_arbiter_pkg.sv
// Shared types and constants for the two-panel vending arbiter.
//   MONEY_W / DRINK_W / DOUT_W : coin, drink-code and dispense widths
//   panel_t                    : panel index (0 or 1)
//   arb_state_t                : arbiter session states
//   panel_onehot()             : panel index -> one-hot grant vector
package vend_pkg;

  localparam int MONEY_W = 6;
  localparam int DRINK_W = 3;
  localparam int DOUT_W  = 4;

  typedef logic panel_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SESSION = 3'd1,
    ST_CANCEL  = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_t;

  function automatic logic [1:0] panel_onehot(panel_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/vend_arbiter_if.sv
// Signal bundle between the two customer panels, the arbiter and the
// vending core.
//   slave  : the arbiter's view (panel + core inputs in, grants/results out)
//   master : the environment's view (panels and core model)
//
// Session protocol: a panel holds req[i] high for as long as it wants the
// core. gnt is one-hot and marks the owner from the grant cycle until the
// session ends. The session ends with a single-cycle done[i] pulse to the
// owner; change_amt (and timed_out for that cycle) are valid while done is
// nonzero, and change_amt holds its value until the next done pulse.
// Dropping req[i] while owning the core aborts the session like a cancel.
interface vend_arbiter_if;
  import vend_pkg::*;

  logic [1:0]         req;
  logic [MONEY_W-1:0] money0;
  logic [MONEY_W-1:0] money1;
  logic [DRINK_W-1:0] choose0;
  logic [DRINK_W-1:0] choose1;
  logic               cancel0;
  logic               cancel1;
  logic [MONEY_W-1:0] core_money;
  logic [DRINK_W-1:0] core_choose;
  logic               core_cancel;
  logic [DOUT_W-1:0]  core_drink_out;
  logic [MONEY_W-1:0] core_change;
  logic [1:0]         gnt;
  logic               busy;
  logic [1:0]         done;
  logic [MONEY_W-1:0] change_amt;
  logic               timed_out;

  modport slave (
    input  req, money0, money1, choose0, choose1, cancel0, cancel1,
    input  core_drink_out, core_change,
    output core_money, core_choose, core_cancel,
    output gnt, busy, done, change_amt, timed_out
  );

  modport master (
    output req, money0, money1, choose0, choose1, cancel0, cancel1,
    output core_drink_out, core_change,
    input  core_money, core_choose, core_cancel,
    input  gnt, busy, done, change_amt, timed_out
  );

endinterface

// File: rtl/vend_arbiter_rr_pick2.sv
// Two-way round-robin picker (combinational).
//   req_i  : per-panel request
//   last_i : panel granted most recently
//   pick_o : one-hot winner, 0 when nobody requests
// A lone request always wins; on a tie the panel that was not served last wins.
module rr_pick2
  import vend_pkg::*;
(
  input  logic [1:0] req_i,
  input  panel_t     last_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = 2'b00;
    case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11:   pick_o = panel_onehot(~last_i);
      default: pick_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/vend_arbiter.sv
// Shares one vending core between two front panels.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : panel requests/inputs, core interface, grant and results
//   dbg_state_o  : current session state
// Parameters: TIMEOUT_CYC (inactivity limit, >=2), DRAIN_CYC (change
// sampling window after session end, >=1).
module vend_arbiter
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int DRAIN_CYC   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  vend_arbiter_if.slave bus,
  output arb_state_t    dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam int DRN_W = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_SAT   = {CNT_W{1'b1}};
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);

  arb_state_t         state_q;
  logic [1:0]         gnt_q;
  panel_t             last_q;
  logic [CNT_W-1:0]   idle_q, idle_d;
  logic [DRN_W-1:0]   drain_q;
  logic               to_q;
  logic [MONEY_W-1:0] chg_q, chg_d;
  logic [1:0]         done_q;
  logic [MONEY_W-1:0] change_amt_q;
  logic               timed_out_q;

  logic [1:0]         pick;
  panel_t             owner;
  logic [MONEY_W-1:0] own_money;
  logic [DRINK_W-1:0] own_choose;
  logic               own_cancel, own_req, own_active;

  rr_pick2 u_pick (
    .req_i  (bus.req),
    .last_i (last_q),
    .pick_o (pick)
  );

  // gnt is one-hot while a session is open, so its upper bit is the owner.
  assign owner      = gnt_q[1];
  assign own_money  = owner ? bus.money1  : bus.money0;
  assign own_choose = owner ? bus.choose1 : bus.choose0;
  assign own_cancel = owner ? bus.cancel1 : bus.cancel0;
  assign own_req    = owner ? bus.req[1]  : bus.req[0];
  assign own_active = (own_money != '0) || (own_choose != '0);

  // Idle count including the current cycle; the timeout fires when it
  // reaches TIMEOUT_CYC-1.
  assign idle_d = own_active ? '0 :
                  (idle_q == IDLE_SAT) ? idle_q : idle_q + CNT_W'(1);

  // Only the first nonzero change sample of the drain window is kept.
  assign chg_d = (chg_q == '0) ? bus.core_change : chg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 2'b00;
      last_q       <= 1'b1;
      idle_q       <= '0;
      drain_q      <= '0;
      to_q         <= 1'b0;
      chg_q        <= '0;
      done_q       <= 2'b00;
      change_amt_q <= '0;
      timed_out_q  <= 1'b0;
    end else begin
      done_q      <= 2'b00;
      timed_out_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick != 2'b00) begin
            gnt_q   <= pick;
            idle_q  <= '0;
            state_q <= ST_SESSION;
          end
        end
        ST_SESSION: begin
          idle_q <= idle_d;
          // A dispense beats a cancel/req-drop, which beats the timeout.
          if (bus.core_drink_out != '0) begin
            drain_q <= '0;
            chg_q   <= '0;
            state_q <= ST_DRAIN;
          end else if (own_cancel || !own_req) begin
            state_q <= ST_CANCEL;
          end else if (idle_d == IDLE_LAST) begin
            to_q    <= 1'b1;
            state_q <= ST_CANCEL;
          end
        end
        ST_CANCEL: begin
          drain_q <= '0;
          chg_q   <= '0;
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          chg_q   <= chg_d;
          drain_q <= drain_q + DRN_W'(1);
          if (drain_q == DRAIN_LAST) begin
            done_q       <= gnt_q;
            change_amt_q <= chg_d;
            timed_out_q  <= to_q;
            state_q      <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          last_q  <= owner;
          gnt_q   <= 2'b00;
          to_q    <= 1'b0;
          idle_q  <= '0;
          drain_q <= '0;
          chg_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.core_money  = (state_q == ST_SESSION) ? own_money  : '0;
  assign bus.core_choose = (state_q == ST_SESSION) ? own_choose : '0;
  assign bus.core_cancel = (state_q == ST_CANCEL);
  assign bus.gnt         = gnt_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.change_amt  = change_amt_q;
  assign bus.timed_out   = timed_out_q;
  assign dbg_state_o     = state_q;

endmodule
